// File: rtl/parity_stream_unit_pkg.sv
// Shared definitions for the parity stream unit: mode encodings, packet FSM
// states and the reduction-parity helper.
package parity_pkg;

    localparam logic MODE_GEN   = 1'b0;
    localparam logic MODE_CHECK = 1'b1;

    // Widest beat the parity helper accepts; narrower beats are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_stream_unit_if.sv
// Beat-level stream bundle between source, parity unit and downstream link.
// Handshake: a beat moves on a rising edge where valid & ready are both high;
// valid never waits on ready, and a valid beat holds all its fields until taken.
interface parity_stream_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_par;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_par;
    logic             out_err;
    logic             out_last;

    // slave: the parity unit; master: the environment driving/consuming it
    modport slave (
        input  in_valid, in_data, in_par, in_last, out_ready,
        output in_ready, out_valid, out_data, out_par, out_err, out_last
    );

    modport master (
        output in_valid, in_data, in_par, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_err, out_last
    );
endinterface

// File: rtl/parity_stream_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment lands on 1 so the concurrent event is not lost.
module parity_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? CNT_W'(1) : '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker: one output register stage, per-packet
// parity/error accumulation and a saturating beat-error counter.
module parity_stream_unit
    import parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_check,
    input  logic                odd_sel,
    input  logic                clr_count,
    parity_stream_unit_if.slave bus,
    output logic                pkt_par,
    output logic                pkt_err,
    output logic [CNT_W-1:0]    err_count,
    output pkt_state_e          dbg_state_o
);
    pkt_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic             odd_q, odd_d;
    logic             acc_x_q, acc_x_d;
    logic             acc_e_q, acc_e_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_par_q, out_par_d;
    logic             out_err_q, out_err_d;
    logic             out_last_q, out_last_d;
    logic             pkt_par_q, pkt_par_d;
    logic             pkt_err_q, pkt_err_d;

    logic accept;
    logic mode_eff;
    logic odd_eff;
    logic data_x;
    logic beat_par;
    logic beat_err;

    // The register can take a new beat whenever its current one leaves this cycle.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // First beat of a packet uses the live controls; later beats the latched ones.
    assign mode_eff = (state_q == IDLE) ? mode_check : mode_q;
    assign odd_eff  = (state_q == IDLE) ? odd_sel    : odd_q;
    assign data_x   = calc_parity(PAR_MAX_W'(bus.in_data), 1'b0);
    assign beat_par = calc_parity(PAR_MAX_W'(bus.in_data), odd_eff);
    assign beat_err = (mode_eff == MODE_CHECK) && (bus.in_par != beat_par);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        odd_d       = odd_q;
        acc_x_d     = acc_x_q;
        acc_e_d     = acc_e_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_par_d   = out_par_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
        pkt_par_d   = pkt_par_q;
        pkt_err_d   = pkt_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
            out_par_d   = (mode_eff == MODE_CHECK) ? bus.in_par : beat_par;
            out_err_d   = beat_err;
            out_last_d  = bus.in_last;
            mode_d      = mode_eff;
            odd_d       = odd_eff;
            if (bus.in_last) begin
                pkt_par_d = acc_x_q ^ data_x ^ odd_eff;
                pkt_err_d = acc_e_q | beat_err;
                acc_x_d   = 1'b0;
                acc_e_d   = 1'b0;
                state_d   = IDLE;
            end else begin
                pkt_par_d = 1'b0;
                pkt_err_d = 1'b0;
                acc_x_d   = acc_x_q ^ data_x;
                acc_e_d   = acc_e_q | beat_err;
                state_d   = IN_PKT;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_GEN;
            odd_q       <= 1'b0;
            acc_x_q     <= 1'b0;
            acc_e_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_par_q   <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            odd_q       <= odd_d;
            acc_x_q     <= acc_x_d;
            acc_e_q     <= acc_e_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
            pkt_par_q   <= pkt_par_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    parity_sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_count),
        .inc_i  (accept && beat_err),
        .count_o(err_count)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_par   = out_par_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_last  = out_last_q;
    assign pkt_par       = pkt_par_q;
    assign pkt_err       = pkt_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_parity_stream_unit.sv
// Bench for parity_stream_unit: directed packets, backpressure, counter
// saturation/clear, mid-packet reset and a random phase, all via a scoreboard.
module tb_parity_stream_unit;
    import parity_pkg::*;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int EW      = WIDTH + 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_check;
    logic             odd_sel;
    logic             clr_count;
    logic             pkt_par;
    logic             pkt_err;
    logic [CNT_W-1:0] err_count;
    pkt_state_e       dbg_state;

    parity_stream_unit_if #(.WIDTH(WIDTH)) bus ();

    parity_stream_unit #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_check (mode_check),
        .odd_sel    (odd_sel),
        .clr_count  (clr_count),
        .bus        (bus),
        .pkt_par    (pkt_par),
        .pkt_err    (pkt_err),
        .err_count  (err_count),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic m_in_pkt = 1'b0;
    logic m_mode   = 1'b0;
    logic m_odd    = 1'b0;
    int   m_ones   = 0;
    logic m_anyerr = 1'b0;
    int   m_cnt    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int ones_of(input logic [WIDTH-1:0] d);
        int c = 0;
        for (int i = 0; i < WIDTH; i++) if (d[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_in_pkt = 1'b0;
        m_ones   = 0;
        m_anyerr = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] d, input logic p, input logic l,
                                input logic m, input logic o, input logic c);
        logic mode, odd, bp, e, opar, pp, pe;
        int   ones;
        mode = m_in_pkt ? m_mode : m;
        odd  = m_in_pkt ? m_odd  : o;
        ones = ones_of(d);
        bp   = ((ones % 2) == 1) ^ odd;
        e    = mode && (p != bp);
        opar = mode ? p : bp;
        if (l) begin
            pp       = (((m_ones + ones) % 2) == 1) ^ odd;
            pe       = m_anyerr | e;
            m_in_pkt = 1'b0;
            m_ones   = 0;
            m_anyerr = 1'b0;
        end else begin
            pp       = 1'b0;
            pe       = 1'b0;
            m_in_pkt = 1'b1;
            m_mode   = mode;
            m_odd    = odd;
            m_ones   = m_ones + ones;
            m_anyerr = m_anyerr | e;
        end
        exp_q.push_back({d, opar, e, l, pp, pe});
        if (c) m_cnt = e ? 1 : 0;
        else if (e && m_cnt < CNT_MAX) m_cnt++;
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [WIDTH-1:0] d, input logic p, input logic l,
                              input logic m, input logic o, input logic c);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_par   = p;
        bus.in_last  = l;
        mode_check   = m;
        odd_sel      = o;
        clr_count    = c;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
        else model_accept(d, p, l, m, o, c);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr_count    = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            logic [EW-1:0] act;
            act = {bus.out_data, bus.out_par, bus.out_err, bus.out_last,
                   bus.out_last & pkt_par, bus.out_last & pkt_err};
            if (exp_q.size() == 0) check_eq("unexpected_beat", 32'(act), 32'hFFFF_FFFF);
            else check_eq("beat", 32'(act), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] bp_data[6];
    int   cnt_seq[5] = '{1, 2, 3, 3, 1};
    logic rnd_done;

    initial begin
        rst           = 1'b1;
        mode_check    = 1'b0;
        odd_sel       = 1'b0;
        clr_count     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_par    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rnd_done      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_pkt_par", 32'(pkt_par), 32'd0);
        check_eq("rst_pkt_err", 32'(pkt_err), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));

        // GEN even single beat
        drive_beat(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // GEN odd 3-beat packet; mode/odd changes after the first beat must be ignored
        drive_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("in_pkt_state", 32'(dbg_state), 32'(IN_PKT));
        drive_beat(8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_beat(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // CHECK even 3-beat packet with one bad beat
        drive_beat(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_beat(8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_beat(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_eq("check_err_count", 32'(err_count), 32'd1);

        // standalone clear
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        m_cnt = 0;
        check_eq("clr_only", 32'(err_count), 32'd0);

        // saturation with a clear coinciding with the fifth error
        for (int i = 0; i < 5; i++) begin
            drive_beat(8'h01, 1'b0, i == 4, 1'b1, 1'b0, i == 4);
            check_eq("sat_count", 32'(err_count), 32'(cnt_seq[i]));
        end
        drain();

        // backpressure: first beat parked in the output register for 3 edges
        for (int i = 0; i < 6; i++) bp_data[i] = WIDTH'($urandom_range(0, 255));
        odd_sel = 1'($urandom_range(0, 1));
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    drive_beat(bp_data[i], 1'b0, i == 5, 1'b0, odd_sel, 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++) begin
                    check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                    check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
                    check_eq("bp_hold_data", 32'(bus.out_data), 32'(bp_data[0]));
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
                #1;
                check_eq("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
            end
        join
        drain();

        // reset in the middle of a CHECK packet that already saw an error
        drive_beat(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_beat(8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_eq("midrst_q_empty", 32'(exp_q.size()), 32'd0);
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_err_count", 32'(err_count), 32'd0);
        check_eq("midrst_state", 32'(dbg_state), 32'(IDLE));
        drive_beat(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_eq("post_rst_count", 32'(err_count), 32'd0);

        // random packets, controls and downstream stalls
        fork
            begin
                for (int i = 0; i < 60; i++)
                    drive_beat(WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                               (i == 59) || ($urandom_range(0, 3) == 0),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        check_eq("rand_err_count", 32'(err_count), 32'(m_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_stream_unit.md
Name: parity_stream_unit

Overview:
Streaming parity generator/checker, successor to the combinational single-word parity block. It accepts WIDTH-bit beats over a valid/ready handshake and operates in one of two modes. GEN mode appends a per-beat parity bit. CHECK mode compares against a received parity bit and flags errors. It also produces per-packet accumulated parity, a packet error flag and a saturating error counter. It sits between a data source and a link/storage interface.

Parameters:
WIDTH, 8, data beat width in bits (>=1)
CNT_W, 16, width of saturating beat-error counter (>=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
mode_check  in  1  0 = GEN, 1 = CHECK; sampled on first beat of a packet
odd_sel  in  1  0 = even parity, 1 = odd parity; sampled with mode_check
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  WIDTH  beat data
in_par  in  1  received parity bit (CHECK mode only, ignored in GEN)
in_last  in  1  final beat of packet
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  WIDTH  registered copy of in_data
out_par  out  1  GEN: computed parity; CHECK: in_par passed through
out_err  out  1  CHECK: beat parity mismatch; GEN: 0
out_last  out  1  registered in_last
pkt_par  out  1  accumulated parity over all packet bits, qualified by out_valid & out_last
pkt_err  out  1  CHECK: any beat error in packet, qualified by out_valid & out_last; GEN: 0
clr_count  in  1  synchronous clear of err_count
err_count  out  CNT_W  saturating count of beat errors since reset/clear

Behaviour:
- Reset: all outputs 0 except in_ready = 1. FSM is in IDLE, accumulators are 0, err_count = 0.
- Beat parity: p = (^in_data) ^ odd_sel_eff. odd_sel_eff is odd_sel on the first beat, else the latched value. Beat error: e = CHECK & (in_par != p).
- Pipeline: one register stage, latency 1 cycle from accept to out_valid. in_ready = !out_valid | out_ready. This gives full throughput with no bubbles.
- Output register loads on accept. It clears out_valid when out_ready is high and no new beat is accepted. Outputs are held stable while out_valid & !out_ready.
- FSM has two states, IDLE and IN_PKT:
  - IDLE, accept with !in_last -> IN_PKT. mode_check and odd_sel are latched.
  - IDLE, accept with in_last -> stays IDLE. This is a single-beat packet using the live mode and odd_sel.
  - IN_PKT, accept with in_last -> IDLE.
  - Changes to mode_check/odd_sel while in IN_PKT are ignored.
- Packet accumulators: acc_x ^= ^in_data and acc_e |= e on each accepted beat. On the last beat:
  - pkt_par = acc_x ^ (^in_data) ^ odd_sel_eff
  - pkt_err = acc_e | e
  - Both accumulators reset to 0 in the same cycle.
- err_count increments on each accepted beat with e = 1. It saturates at 2^CNT_W-1 with no wrap.
- If clr_count and an error beat occur in the same cycle, err_count = 1. If clr_count occurs with no error, err_count = 0.
- Reset mid-packet discards the partial packet: FSM goes to IDLE, accumulators clear, out_valid = 0. The next accepted beat starts a new packet.
- in_valid low: no state changes apart from output drain.

Decomposition:
- Shared package parity_pkg holds:
  - the MODE_GEN/MODE_CHECK constants
  - the FSM state enum (IDLE, IN_PKT)
  - a function computing reduction parity with odd select
- One natural sub-module: parity_sat_counter, a CNT_W saturating counter with synchronous clear and increment, where clear+inc yields 1.

Test Plan:
- GEN even, single beat 8'hA5, in_last=1 -> next cycle out_par=0, pkt_par=0, out_err=0, pkt_err=0.
- GEN odd, 3-beat packet 8'h01, 8'h03, 8'h00 -> out_par = 0, 1, 1; pkt_par on last beat = 0 (three ones, odd mode).
- CHECK even, beats {8'h0F, in_par=0}, {8'h07, in_par=0}, last {8'h00, in_par=0} -> out_err = 0, 1, 0; pkt_err=1; err_count=1.
- Backpressure: out_ready=0 for 3 cycles with continuous in_valid -> one beat held in the output register, in_ready=0, outputs stable. On out_ready=1, in_ready rises the same cycle, and no beats are lost or duplicated (scoreboard against ^data).
- CNT_W=2, 5 error beats with clr_count pulsed together with the 5th -> count sequence 1, 2, 3, 3, then 1 after the clear cycle.
- rst asserted after beat 2 of a 4-beat CHECK packet containing an error -> out_valid=0, err_count=0. The next single-beat packet 8'h00 with in_par=0 gives pkt_err=0 and pkt_par=0.
